idecode_cu_issue: RTL



---
 rtl/idecode_cu_issue_pkg.sv | 45 ++++
 rtl/idecode_cu_issue_if.sv | 24 ++
 rtl/idecode_bht.sv | 30 +++
 rtl/idecode_cu_issue.sv | 98 +++++++++
 4 files changed

// File: rtl/idecode_cu_issue_pkg.sv
// Shared definitions for the decode-to-CU issue stage: bundle layout, opcode map entry, reset values.
// No logic; constants and one helper used by the RTL.
package idecode_cu_issue_pkg;

  localparam int OPC_W     = 6;
  localparam int OPC_LSB   = 26;
  localparam int OPC_MSB   = 31;
  localparam int BHT_IDX_W = 4;
  localparam int MAP_DEPTH = 1 << OPC_W;
  localparam int BUNDLE_W  = 92;

  localparam logic [7:0] NOP_ADDR = 8'hFF;
  localparam logic [1:0] BHT_INIT = 2'b01;

  // Bundle slicing must match the CU-side decode of idecode_cu_interface.
  localparam int B_INSTR_LSB   = 0;
  localparam int B_INSTR_MSB   = 31;
  localparam int B_MC_ADDR_LSB = 32;
  localparam int B_MC_ADDR_MSB = 39;
  localparam int B_MC_CNT_LSB  = 40;
  localparam int B_MC_CNT_MSB  = 42;
  localparam int B_IADDR_LSB   = 43;
  localparam int B_IADDR_MSB   = 50;
  localparam int B_NT_LSB      = 75;
  localparam int B_NT_MSB      = 82;
  localparam int B_BR_LSB      = 83;
  localparam int B_BR_MSB      = 90;
  localparam int B_PRED        = 91;

  typedef struct packed {
    logic       is_branch;
    logic [2:0] cnt;
    logic [7:0] addr;
  } map_entry_t;

  localparam map_entry_t MAP_INIT = '{is_branch: 1'b0, cnt: 3'd0, addr: NOP_ADDR};

  function automatic logic [BUNDLE_W-1:0] nop_bundle();
    logic [BUNDLE_W-1:0] b;
    b = '0;
    b[B_MC_ADDR_MSB:B_MC_ADDR_LSB] = NOP_ADDR;
    return b;
  endfunction

endpackage

// File: rtl/idecode_cu_issue_if.sv
// Fetch/issue/redirect signals between the decode stage (master) and its fetch/CU environment (slave).
interface idecode_cu_issue_if;
  import idecode_cu_issue_pkg::*;

  logic [31:0]         instr_in;
  logic [7:0]          instr_addr_in;
  logic                instr_valid_in;
  logic                instr_ready_out;
  logic                exec_ready_cu;
  logic [BUNDLE_W-1:0] idecode_cu_interface;
  logic                redirect_valid;
  logic [7:0]          redirect_addr;

  modport master (
    input  instr_in, instr_addr_in, instr_valid_in, exec_ready_cu,
    output instr_ready_out, idecode_cu_interface, redirect_valid, redirect_addr
  );

  modport slave (
    output instr_in, instr_addr_in, instr_valid_in, exec_ready_cu,
    input  instr_ready_out, idecode_cu_interface, redirect_valid, redirect_addr
  );

endinterface

// File: rtl/idecode_bht.sv
// 16-entry 2-bit saturating branch history table; combinational read, update at the edge.
// Latency: read 0 cycles, update visible next cycle; no backpressure.
module idecode_bht
  import idecode_cu_issue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_ctr,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  logic [1:0] ctr_q [1 << BHT_IDX_W];

  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1 << BHT_IDX_W); i++) ctr_q[i] <= BHT_INIT;
    end else if (upd_valid) begin
      if (upd_taken && ctr_q[upd_idx] != 2'b11)
        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
      else if (!upd_taken && ctr_q[upd_idx] != 2'b00)
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/idecode_cu_issue.sv
// Decode issue stage: opcode-map lookup + BHT prediction into a 92-bit CU bundle, 1-cycle latency.
// Backpressure: bundle held while CU not exec-ready; instr_ready_out = !out_valid | exec_ready_cu.
module idecode_cu_issue
  import idecode_cu_issue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_pipeline,
  idecode_cu_issue_if.master       cu,
  input  logic                     map_we,
  input  logic [OPC_W-1:0]         map_waddr,
  input  logic [11:0]              map_wdata,
  input  logic                     bp_upd_valid,
  input  logic [7:0]               bp_upd_addr,
  input  logic                     bp_upd_taken
);

  map_entry_t          map_q [MAP_DEPTH];
  map_entry_t          lkp;
  logic [1:0]          bht_ctr;
  logic                pred;
  logic                load;
  logic                out_valid;
  logic [7:0]          nt_addr;
  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_q;
  logic                redirect_valid_q;
  logic [7:0]          redirect_addr_q;
  logic                unused_bp_hi;

  assign unused_bp_hi = ^bp_upd_addr[7:BHT_IDX_W];

  idecode_bht u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (cu.instr_addr_in[BHT_IDX_W-1:0]),
    .rd_ctr    (bht_ctr),
    .upd_valid (bp_upd_valid),
    .upd_idx   (bp_upd_addr[BHT_IDX_W-1:0]),
    .upd_taken (bp_upd_taken)
  );

  assign lkp     = map_q[cu.instr_in[OPC_MSB:OPC_LSB]];
  assign pred    = lkp.is_branch & bht_ctr[1];
  assign nt_addr = cu.instr_addr_in + 8'd1;

  assign cu.instr_ready_out = rst & ~flush_pipeline & (~out_valid | cu.exec_ready_cu);
  assign load               = cu.instr_valid_in & cu.instr_ready_out;

  always_comb begin
    bundle_d = '0;
    bundle_d[B_INSTR_MSB:B_INSTR_LSB]     = cu.instr_in;
    bundle_d[B_MC_ADDR_MSB:B_MC_ADDR_LSB] = lkp.addr;
    bundle_d[B_MC_CNT_MSB:B_MC_CNT_LSB]   = lkp.cnt;
    bundle_d[B_IADDR_MSB:B_IADDR_LSB]     = cu.instr_addr_in;
    bundle_d[B_NT_MSB:B_NT_LSB]           = nt_addr;
    bundle_d[B_BR_MSB:B_BR_LSB]           = cu.instr_addr_in;
    bundle_d[B_PRED]                      = pred;
  end

  // An empty slot always presents the NOP encoding so the CU never sees stale fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bundle_q         <= nop_bundle();
      out_valid        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= 8'h00;
    end else if (flush_pipeline) begin
      bundle_q         <= nop_bundle();
      out_valid        <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else if (load) begin
      bundle_q         <= bundle_d;
      out_valid        <= 1'b1;
      redirect_valid_q <= pred;
      if (pred) redirect_addr_q <= cu.instr_in[7:0];
    end else begin
      redirect_valid_q <= 1'b0;
      if (cu.exec_ready_cu) begin
        bundle_q  <= nop_bundle();
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAP_DEPTH; i++) map_q[i] <= MAP_INIT;
    end else if (map_we) begin
      map_q[map_waddr] <= map_entry_t'(map_wdata);
    end
  end

  assign cu.idecode_cu_interface = bundle_q;
  assign cu.redirect_valid       = redirect_valid_q;
  assign cu.redirect_addr        = redirect_addr_q;

endmodule
